// File: rtl/alu_pkg.sv
// Shared ALU op codes and multiplier sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_NAND = 3'b011;
    localparam logic [2:0] ALU_SLR  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_HALT = 3'b110;
    localparam logic [2:0] ALU_EQ   = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        DONE = 3'd4
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that time-shares the external ALU.
// Optional MUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_r_q, ovf_r_d;
    logic [WIDTH-1:0] product_d;
    logic             ovf_d;
    logic             busy_d, done_d;
    logic             last_iter;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            ovf_r_q  <= 1'b0;
            product  <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            ovf_r_q  <= ovf_r_d;
            product  <= product_d;
            ovf      <= ovf_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next state, datapath updates and ALU drive
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        ovf_r_d   = ovf_r_q;
        product_d = product;
        ovf_d     = ovf;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = ALU_ADD;
        last_iter = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = a;
                    mplier_d = b;
                    cnt_d    = '0;
                    ovf_r_d  = 1'b0;
                    state_d  = b[0] ? ADD : SHL;
`ifdef MUL_EARLY_EXIT_EN
                    if (b == '0) begin
                        state_d   = DONE;
                        product_d = '0;
                        ovf_d     = 1'b0;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                alu_a = acc_q;
                alu_b = mcand_q;
                acc_d = alu_result;
                if (alu_result < acc_q) ovf_r_d = 1'b1;
                state_d = SHL;
            end
            SHL: begin
                alu_a    = mcand_q;
                alu_ctrl = ALU_SLL;
                mcand_d  = alu_result;
                // A set bit leaves the top while later multiplier bits still need it
                if (mcand_q[WIDTH-1] && (mplier_q[WIDTH-1:1] != '0)) ovf_r_d = 1'b1;
                state_d = SHR;
            end
            SHR: begin
                alu_a     = mplier_q;
                alu_ctrl  = ALU_SLR;
                mplier_d  = alu_result;
                cnt_d     = cnt_q + CNT_W'(1);
                last_iter = (cnt_q == LAST_CNT);
`ifdef MUL_EARLY_EXIT_EN
                if (alu_result == '0) last_iter = 1'b1;
`endif
                if (last_iter) begin
                    state_d   = DONE;
                    product_d = acc_q;
                    ovf_d     = ovf_r_q;
                end else begin
                    state_d = alu_result[0] ? ADD : SHL;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ADD) || (state_d == SHL) || (state_d == SHR);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench: alu_mul_seq plus a behavioural ALU, checked against a transaction-level model.
module tb_alu_mul_seq;
    import alu_pkg::*;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, ovf;
    logic [W-1:0] product, alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctrl;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    alu_mul_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product), .ovf(ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Behavioural ALU sitting beside the sequencer
    always_comb begin
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLR: alu_result = alu_a >> 1;
            ALU_SLL: alu_result = alu_a << 1;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Busy cycles between the start edge and the DONE state
    function automatic int exp_busy(input logic [W-1:0] bv);
        int p;
        int top;
        p = $countones(bv);
        top = 0;
        for (int i = 0; i < int'(W); i++) if (bv[i]) top = i + 1;
`ifdef MUL_EARLY_EXIT_EN
        return 2 * top + p;
`else
        return 2 * int'(W) + p;
`endif
    endfunction

    // Transaction-level model: outcome from plain multiplication, timing from bit counts
    bit           m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;
    logic [W-1:0] m_prod = '0, p_prod = '0;
    int           m_rem = 0;

    always @(posedge clk) begin
        int unsigned full;
        started <= 1'b1;
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_prod <= '0; m_ovf <= 1'b0; m_rem <= 0;
        end else if (!m_busy && start) begin
            full = int'(a) * int'(b);
            if (exp_busy(b) == 0) begin
                m_done <= 1'b1; m_prod <= '0; m_ovf <= 1'b0;
            end else begin
                m_busy <= 1'b1; m_done <= 1'b0; m_rem <= exp_busy(b);
                p_prod <= W'(full); p_ovf <= (full >= (1 << W));
            end
        end else if (m_busy) begin
            if (m_rem == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_prod <= p_prod; m_ovf <= p_ovf;
            end
            m_rem <= m_rem - 1;
        end else begin
            m_done <= 1'b0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("product", product, m_prod);
            chk("ovf", ovf, m_ovf);
            chk("alu_ctrl_legal", (alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SLR), 1);
            if (!m_busy) begin
                chk("idle_ctrl", alu_ctrl, 0);
                chk("idle_alu_a", alu_a, 0);
                chk("idle_alu_b", alu_b, 0);
            end
        end
    end

    // Issue a multiply at the current negedge; returns at the negedge showing done.
    // poke>=0 pulses a stray start that many cycles after the start edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int poke, output int lat);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        lat = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (lat > 100) begin
                chk("done_timeout", 0, 1);
                break;
            end
            if (lat == poke) begin
                a = W'($urandom); b = W'($urandom); start = 1'b1;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int unsigned full;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_product", product, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ctrl", alu_ctrl, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(W'(3), W'(5), -1, lat);
        chk("mul3x5_product", product, 15);
        chk("mul3x5_ovf", ovf, 0);
`ifdef MUL_EARLY_EXIT_EN
        chk("mul3x5_latency", lat, 8);
`else
        chk("mul3x5_latency", lat, 22);
`endif
        @(negedge clk);

        run_op(W'(100), W'(20), -1, lat);
        chk("mul100x20_product", product, 976);
        chk("mul100x20_ovf", ovf, 1);
        @(negedge clk);

        run_op(W'(1023), W'(0), -1, lat);
        chk("mul1023x0_product", product, 0);
        chk("mul1023x0_ovf", ovf, 0);
`ifdef MUL_EARLY_EXIT_EN
        // done appears in the cycle right after the start cycle
        chk("mul1023x0_latency", lat, 0);
`else
        chk("mul1023x0_latency", lat, 20);
`endif
        @(negedge clk);

        // Stray start while busy, then a start in the DONE cycle
        run_op(W'(3), W'(5), 3, lat);
        chk("ignored_start_product", product, 15);
        run_op(W'(7), W'(6), -1, lat);
        chk("b2b_product", product, 42);
`ifdef MUL_EARLY_EXIT_EN
        chk("b2b_latency", lat, 8);
`else
        chk("b2b_latency", lat, 22);
`endif
        @(negedge clk);

        // Reset while in SHL of 3*5
        a = W'(3); b = W'(5); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_product", product, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_op(W'(2), W'(2), -1, lat);
        chk("after_rst_product", product, 4);
        @(negedge clk);

        // Randomized operands, stray starts and back-to-back issue
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            full = int'(ra) * int'(rb);
            run_op(ra, rb, (exp_busy(rb) > 4) ? int'($urandom_range(0, 3)) : -1, lat);
            chk("rand_product", product, full % (1 << W));
            chk("rand_ovf", ovf, (full >= (1 << W)) ? 1 : 0);
            chk("rand_latency", lat, exp_busy(rb));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
